// File: rtl/pwc_pkg.sv
// Shared constants and types for the programmable wrap/saturate counter.
package pwc_pkg;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_t;
endpackage

// File: rtl/pwc_prescaler.sv
// Step generator: asserts STEP once every PRESCALE enabled, non-cleared cycles.
module pwc_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic EN,
  input  logic CLR,
  output logic STEP
);
  generate
    if (PRESCALE > 1) begin : g_div
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] cnt;

      assign STEP = EN & ~CLR & (cnt == LAST);

      // CLR restarts the period; EN low freezes it mid-way.
      always_ff @(posedge CLK) begin
        if (!RST_N)      cnt <= '0;
        else if (CLR)    cnt <= '0;
        else if (EN)     cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
      end
    end else begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ RST_N;
      assign STEP = EN & ~CLR;
    end
  endgenerate
endmodule

// File: rtl/prog_wrap_counter.sv
// Up/down counter with runtime limit, wrap or saturate, load, prescaler,
// terminal-count pulse and sticky overflow flag.
module prog_wrap_counter
  import pwc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             DIR,
  input  logic             MODE,
  input  logic [WIDTH-1:0] LIMIT,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] CNT,
  output logic             TC,
  output logic             OVF
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             step;
  logic             bnd;
  logic [WIDTH-1:0] nxt;
  cnt_mode_t        mode;

  assign mode = cnt_mode_t'(MODE);

  pwc_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (EN),
    .CLR  (LOAD),
    .STEP (step)
  );

  // Up boundary uses >= so a LIMIT lowered below CNT still terminates.
  always_comb begin
    bnd = 1'b0;
    nxt = CNT;
    if (DIR == DIR_UP) begin
      if (CNT < LIMIT) nxt = CNT + ONE;
      else begin
        bnd = 1'b1;
        nxt = (mode == MODE_SAT) ? CNT : '0;
      end
    end else begin
      if (CNT != '0) nxt = CNT - ONE;
      else begin
        bnd = 1'b1;
        nxt = (mode == MODE_SAT) ? '0 : LIMIT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      CNT <= '0;
      TC  <= 1'b0;
      OVF <= 1'b0;
    end else begin
      if (CLR_OVF) OVF <= 1'b0;
      if (LOAD) begin
        CNT <= LOAD_VAL;
        TC  <= 1'b0;
      end else if (step) begin
        CNT <= nxt;
        TC  <= bnd;
        if (bnd) OVF <= 1'b1;  // later assignment: set beats clear
      end else begin
        TC <= 1'b0;
      end
    end
  end
endmodule
